// File: rtl/led_sig_decoder.sv
// led_sig_decoder: single-wire LED data decoder (WS2812-style NRZ pulse-width stream,
// GRB order, MSB first). Recovers 24-bit pixels, numbers them within a frame, and flags
// latch gaps and timing errors.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous active-low reset
//   led_sig    in   serial LED data line, asynchronous to clk
//   pix_data   out  decoded pixel {G,R,B}, first received bit at [23]; holds until next pixel
//   pix_valid  out  one-cycle strobe, pix_data/pix_index valid
//   pix_index  out  0-based pixel position in the current frame (saturates)
//   frame_end  out  one-cycle strobe on a latch gap after at least one bit
//   bit_err    out  one-cycle strobe on a timing error or a partial pixel at latch
//
// Build option: define LED_DEC_GLITCH_FILTER_EN to add a 3-sample stability filter after
// the synchroniser (suppresses 1-2 cycle pulses, adds 2 cycles of event latency).
module led_sig_decoder #(
  parameter int unsigned THRESH_CYC   = 30,
  parameter int unsigned MIN_HIGH_CYC = 8,
  parameter int unsigned MAX_HIGH_CYC = 55,
  parameter int unsigned RESET_CYC    = 2500,
  parameter int unsigned IDX_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             led_sig,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_index,
  output logic             frame_end,
  output logic             bit_err
);

  localparam int unsigned HcW = $clog2(MAX_HIGH_CYC + 2);
  localparam int unsigned LcW = $clog2(RESET_CYC + 1);

  localparam logic [HcW-1:0] HcThresh = HcW'(THRESH_CYC);
  localparam logic [HcW-1:0] HcMin    = HcW'(MIN_HIGH_CYC);
  localparam logic [HcW-1:0] HcMax    = HcW'(MAX_HIGH_CYC);
  localparam logic [LcW-1:0] LcReset  = LcW'(RESET_CYC);

  typedef enum logic [1:0] {StGap, StHigh, StLow, StErr} state_e;

  // ---------------------------------------------------------------------------------------
  // Input path: 2-flop synchroniser, optional stability filter, registered edge detect.
  // ---------------------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= led_sig;
      sync2_q <= sync1_q;
    end
  end

`ifdef LED_DEC_GLITCH_FILTER_EN
  // Filtered level follows the synchroniser only after 3 equal consecutive samples.
  localparam logic [2:0] FillCyc = 3'd5;
  logic tap1_q, tap2_q, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap1_q <= 1'b0;
      tap2_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      tap1_q <= sync2_q;
      tap2_q <= tap1_q;
      filt_q <= lvl;
    end
  end

  always_comb begin
    lvl = filt_q;
    if ((sync2_q == tap1_q) && (tap1_q == tap2_q)) lvl = sync2_q;
  end
`else
  localparam logic [2:0] FillCyc = 3'd3;
  assign lvl = sync2_q;
`endif

  // Edges are only trusted once lvl_q holds a real sample of the pin; this keeps a line
  // that is already high at reset release from looking like a fresh rise.
  logic [2:0] fill_q;
  logic       lvl_q, rise_q, fall_q;
  logic       armed;

  assign armed = (fill_q == FillCyc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 3'd0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      if (!armed) fill_q <= fill_q + 3'd1;
      lvl_q  <= lvl;
      rise_q <= lvl & ~lvl_q & armed;
      fall_q <= ~lvl & lvl_q & armed;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Decoder FSM with registered outputs.
  // ---------------------------------------------------------------------------------------
  state_e         state_q;
  logic [HcW-1:0] hcnt_q;
  logic [LcW-1:0] lcnt_q;
  logic [4:0]     bcnt_q;
  logic [23:0]    shift_q;
  logic           got_bit_q;
  logic           idx_clr_q;
  logic [23:0]    shift_nxt;

  assign shift_nxt = {shift_q[22:0], (hcnt_q >= HcThresh)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StGap;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      bcnt_q    <= 5'd0;
      shift_q   <= 24'd0;
      got_bit_q <= 1'b0;
      idx_clr_q <= 1'b0;
      pix_data  <= 24'd0;
      pix_valid <= 1'b0;
      pix_index <= '0;
      frame_end <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      frame_end <= 1'b0;
      bit_err   <= 1'b0;
      idx_clr_q <= 1'b0;

      // Index shows the current pixel during pix_valid, then advances (no wrap).
      if (idx_clr_q) begin
        pix_index <= '0;
      end else if (pix_valid && (pix_index != '1)) begin
        pix_index <= pix_index + IDX_W'(1);
      end

      unique case (state_q)
        StGap: begin
          if (rise_q) begin
            state_q <= StHigh;
            hcnt_q  <= HcW'(1);
          end
        end

        StHigh: begin
          if (fall_q) begin
            if (hcnt_q < HcMin) begin
              state_q <= StErr;
              bit_err <= 1'b1;
              bcnt_q  <= 5'd0;
              shift_q <= 24'd0;
              lcnt_q  <= '0;
            end else begin
              state_q   <= StLow;
              lcnt_q    <= LcW'(1);
              got_bit_q <= 1'b1;
              if (bcnt_q == 5'd23) begin
                pix_data  <= shift_nxt;
                pix_valid <= 1'b1;
                bcnt_q    <= 5'd0;
                shift_q   <= 24'd0;
              end else begin
                bcnt_q  <= bcnt_q + 5'd1;
                shift_q <= shift_nxt;
              end
            end
          end else begin
            hcnt_q <= hcnt_q + HcW'(1);
            // Still high after MAX_HIGH_CYC cycles: flag now, don't wait for the fall.
            if (hcnt_q >= HcMax) begin
              state_q <= StErr;
              bit_err <= 1'b1;
              bcnt_q  <= 5'd0;
              shift_q <= 24'd0;
              lcnt_q  <= '0;
            end
          end
        end

        StLow: begin
          if (lcnt_q >= LcReset) begin
            // Latch wins over a coincident rise; that rise opens the next frame.
            frame_end <= got_bit_q;
            bit_err   <= (bcnt_q != 5'd0);
            bcnt_q    <= 5'd0;
            shift_q   <= 24'd0;
            got_bit_q <= 1'b0;
            idx_clr_q <= 1'b1;
            if (rise_q) begin
              state_q <= StHigh;
              hcnt_q  <= HcW'(1);
            end else begin
              state_q <= StGap;
            end
          end else if (rise_q) begin
            state_q <= StHigh;
            hcnt_q  <= HcW'(1);
          end else begin
            lcnt_q <= lcnt_q + LcW'(1);
          end
        end

        StErr: begin
          // Wait for an unbroken low of RESET_CYC; leave silently.
          if (lvl_q) begin
            lcnt_q <= '0;
          end else if (lcnt_q >= LcReset) begin
            state_q   <= StGap;
            got_bit_q <= 1'b0;
            idx_clr_q <= 1'b1;
          end else begin
            lcnt_q <= lcnt_q + LcW'(1);
          end
        end

        default: state_q <= StGap;
      endcase
    end
  end

endmodule
